cam_init_seq: RTL and testbench
===============================

Name: cam_init_seq

Overview:
Power-up and register-initialisation sequencer for the MIPI camera sensor. It drives the sensor reset pin through tristate controls, waits the required timing, then walks a register table and issues one I2C write per entry to a byte-level I2C master. Sits between the top-level IOBUFs and the camera I2C master. It replaces manual reset control from the debug VIO.

Parameters:
CLK_FREQ_HZ, 50000000, clk_50m frequency; TICK_DIV = CLK_FREQ_HZ/1000000 cycles per microsecond tick
RST_LOW_US, 1000, reset-asserted time in us
RST_WAIT_US, 20000, post-release settle time in us
TBL_AW, 6, table address width (64 entries)
DEV_ADDR, 7'h36, 7-bit sensor I2C address
MAX_RETRY, 3, NACK retries per entry before error
TIMEOUT_CYC, 100000, response watchdog (feature-gated)

Ports:
clk_50m  in  1  system clock
reset_in  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; begins a sequence from IDLE, DONE or ERROR
tbl_addr  out  TBL_AW  table read address
tbl_data  in  32  {op[31:24], reg[23:8], val[7:0]}, valid 1 cycle after tbl_addr changes
cmd_valid  out  1  I2C write request
cmd_ready  in  1  I2C master accepts
cmd_dev  out  7  device address (DEV_ADDR)
cmd_reg  out  16  register address
cmd_data  out  8  write data
rsp_valid  in  1  transfer finished pulse
rsp_nack  in  1  qualified by rsp_valid; 1 = NACK
cam_rst_o  out  1  reset pin drive value
cam_rst_t  out  1  reset pin tristate (1 = hi-Z)
busy  out  1  sequence in progress
done  out  1  table completed successfully (sticky until start)
error  out  1  sequence aborted (sticky until start)
err_index  out  TBL_AW  table index of failing entry

Behaviour:
- Reset values: state IDLE; tbl_addr 0; cmd_valid 0; cmd_reg/cmd_data 0; cam_rst_o 0, cam_rst_t 0 (sensor held in reset); busy/done/error 0; err_index 0. cmd_dev is constant DEV_ADDR.
- us tick: free-running prescaler 0..TICK_DIV-1, tick on wrap; cleared on every state entry so delays are exact: N us = N*TICK_DIV cycles +/-1.
- States:
  IDLE: pin held low; start -> RST_ASSERT.
  RST_ASSERT: rst_o=0, t=0, busy=1, done/error cleared; after RST_LOW_US -> RST_WAIT.
  RST_WAIT: t=1 (released, external pull-up); after RST_WAIT_US -> FETCH with tbl_addr=0.
  FETCH: one wait cycle for ROM latency -> DECODE.
  DECODE: op 0x00 WRITE -> I2C_REQ (retry cnt=0); 0x01 DELAY -> DELAY for val ms (val*1000 us; val=0 means 0 wait, next cycle advance); 0xFF END -> DONE; any other op -> ERROR.
  I2C_REQ: cmd_valid=1, fields stable until cmd_valid&cmd_ready; then -> I2C_WAIT.
  I2C_WAIT: on rsp_valid & !rsp_nack -> advance; on NACK: retry<MAX_RETRY -> retry++, I2C_REQ; else ERROR.
  advance: tbl_addr++ -> FETCH; if tbl_addr was all-ones (last entry, no END) -> DONE.
  DONE: done=1, busy=0, pin stays released. ERROR: error=1, busy=0, err_index=tbl_addr, pin driven low again (rst_o=0, t=0).
- start while busy: ignored. rsp_valid outside I2C_WAIT: ignored.
- reset_in mid-sequence: all state to reset values immediately; sensor returns to reset.

Optional Feature:
CAM_INIT_TIMEOUT_EN: defined -> counter in I2C_WAIT; reaching TIMEOUT_CYC without rsp_valid is treated as NACK (consumes a retry). Undefined -> I2C_WAIT waits indefinitely; counter not built.

Decomposition:
- Package cam_init_pkg: opcode constants OP_WRITE=8'h00, OP_DELAY=8'h01, OP_END=8'hFF; state encoding; table-entry field offsets.
- One sub-module: cam_init_us_timer (prescaler plus loadable us down-counter, load/expired handshake), reused for RST_LOW, RST_WAIT, DELAY.

Test Plan:
- RST_LOW_US=2, RST_WAIT_US=3, start pulse -> cam_rst_t=0 for 100 cycles, t=1, first cmd_valid 150 cycles later (+/-2).
- Table {W 0x0100=0x01, W 0x0103=0x01, END}, master ACK -> two requests with cmd_reg 0x0100/0x0103, data 0x01, dev 0x36; done=1, busy=0.
- Entry 1 NACKs 4 times, MAX_RETRY=3 -> 4 requests total, error=1, err_index=1, cam_rst_t=0.
- DELAY entry val=2 -> next cmd_valid 100000 cycles after preceding rsp_valid (+/-3).
- reset_in asserted in I2C_WAIT -> next cycle cmd_valid=0, busy=0, cam_rst_t=0; later start reruns from entry 0.
- With CAM_INIT_TIMEOUT_EN, TIMEOUT_CYC=50, no rsp_valid -> 4 requests 50+ cycles apart, then error=1.

Source files
------------

// File: rtl/cam_init_pkg.sv
// cam_init_pkg: shared definitions for the camera power-up / register-init sequencer.
//   - table opcodes, table-entry field positions, sequencer state encoding
//   - microsecond counter width and the ms->us helper used for DELAY entries
package cam_init_pkg;

  // Table opcodes (entry bits [31:24])
  localparam logic [7:0] OP_WRITE = 8'h00;
  localparam logic [7:0] OP_DELAY = 8'h01;
  localparam logic [7:0] OP_END   = 8'hFF;

  // Table entry layout: {op, reg, val}
  localparam int unsigned ENTRY_W = 32;
  localparam int unsigned OP_LSB  = 24;
  localparam int unsigned OP_W    = 8;
  localparam int unsigned REG_LSB = 8;
  localparam int unsigned REG_W   = 16;
  localparam int unsigned VAL_LSB = 0;
  localparam int unsigned VAL_W   = 8;

  // Microsecond counter width; covers 255 ms DELAY entries and the reset timings
  localparam int unsigned US_W = 20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_ASSERT,
    ST_RST_WAIT,
    ST_FETCH,
    ST_DECODE,
    ST_I2C_REQ,
    ST_I2C_WAIT,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } state_e;

  // DELAY entries carry milliseconds; the timer counts microseconds
  function automatic logic [US_W-1:0] ms_to_us(input logic [VAL_W-1:0] ms);
    return US_W'(ms) * US_W'(1000);
  endfunction

endpackage

// File: rtl/cam_init_us_timer.sv
// cam_init_us_timer: microsecond delay timer.
//   clk, rst      : clock, asynchronous active-high reset
//   load_i        : restart the delay (clears the prescaler, loads load_us_i)
//   load_us_i     : delay length in microseconds (0 = already expired)
//   expired_c     : combinational; high in the last cycle of the delay and after,
//                   so an FSM leaving on it spends exactly N*TICK_DIV cycles in state
module cam_init_us_timer
  import cam_init_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [US_W-1:0] load_us_i,
  output logic            expired_c
);

  localparam int unsigned     PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [US_W-1:0]  cnt_q, cnt_d;
  logic             wrap;

  // Prescaler runs only while a delay is pending; wrap marks one elapsed microsecond
  always_comb begin
    wrap  = (pre_q == PRE_LAST);
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (load_i) begin
      pre_d = '0;
      cnt_d = load_us_i;
    end else if (cnt_q != '0) begin
      if (wrap) begin
        pre_d = '0;
        cnt_d = cnt_q - US_W'(1);
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  // Look-ahead on the final tick hides the FSM's one-cycle reaction latency
  assign expired_c = (cnt_q == '0) || ((cnt_q == US_W'(1)) && wrap);

endmodule

// File: rtl/cam_init_seq.sv
// cam_init_seq: camera sensor power-up and register-initialisation sequencer.
// Holds the sensor in reset, releases it, waits for it to settle, then walks a
// register table issuing one I2C write per WRITE entry.
// Ports:
//   clk_50m, reset_in        : clock, asynchronous active-high reset
//   start                    : pulse; starts a sequence from IDLE, DONE or ERROR
//   tbl_addr / tbl_data      : table ROM (data valid one cycle after the address)
//   cmd_valid/ready/dev/reg/data : write request to the byte-level I2C master
//   rsp_valid / rsp_nack     : transfer completion and NACK flag
//   cam_rst_o / cam_rst_t    : reset pin drive value and tristate (1 = released)
//   busy, done, error, err_index : status; done/error sticky until the next start
// Build option: define CAM_INIT_TIMEOUT_EN to add a response watchdog in
// I2C_WAIT (TIMEOUT_CYC cycles without rsp_valid counts as a NACK).
module cam_init_seq
  import cam_init_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned RST_LOW_US  = 1000,
  parameter int unsigned RST_WAIT_US = 20000,
  parameter int unsigned TBL_AW      = 6,
  parameter logic [6:0]  DEV_ADDR    = 7'h36,
  parameter int unsigned MAX_RETRY   = 3
`ifdef CAM_INIT_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 100000
`endif
) (
  input  logic              clk_50m,
  input  logic              reset_in,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [31:0]       tbl_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [6:0]        cmd_dev,
  output logic [15:0]       cmd_reg,
  output logic [7:0]        cmd_data,
  input  logic              rsp_valid,
  input  logic              rsp_nack,
  output logic              cam_rst_o,
  output logic              cam_rst_t,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TBL_AW-1:0] err_index
);

  localparam int unsigned TICK_DIV = CLK_FREQ_HZ / 1000000;
  localparam int unsigned RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e              state_q, state_d;
  logic [TBL_AW-1:0]   tbl_addr_q, tbl_addr_d;
  logic [TBL_AW-1:0]   err_index_q, err_index_d;
  logic [REG_W-1:0]    cmd_reg_q, cmd_reg_d;
  logic [VAL_W-1:0]    cmd_data_q, cmd_data_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                cam_rst_t_q, cam_rst_t_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic [OP_W-1:0]     ent_op;
  logic [REG_W-1:0]    ent_reg;
  logic [VAL_W-1:0]    ent_val;
  logic                tmr_load;
  logic [US_W-1:0]     tmr_us;
  logic                tmr_expired_c;
  logic                advance;
  logic                rsp_ok;
  logic                rsp_fail;
  logic                tmo_c;

  assign ent_op  = tbl_data[OP_LSB +: OP_W];
  assign ent_reg = tbl_data[REG_LSB +: REG_W];
  assign ent_val = tbl_data[VAL_LSB +: VAL_W];

  // One timer shared by RST_ASSERT, RST_WAIT and DELAY; loaded on state entry
  cam_init_us_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk       (clk_50m),
    .rst       (reset_in),
    .load_i    (tmr_load),
    .load_us_i (tmr_us),
    .expired_c (tmr_expired_c)
  );

`ifdef CAM_INIT_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts cycles spent in I2C_WAIT; restarts from zero on every entry
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ST_I2C_WAIT) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_50m or posedge reset_in) begin
    if (reset_in) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign tmo_c = (state_q == ST_I2C_WAIT) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_c = 1'b0;
`endif

  // A real response always wins over a coincident watchdog expiry
  assign rsp_ok   = rsp_valid && !rsp_nack;
  assign rsp_fail = (rsp_valid && rsp_nack) || (!rsp_valid && tmo_c);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    tbl_addr_d  = tbl_addr_q;
    err_index_d = err_index_q;
    cmd_reg_d   = cmd_reg_q;
    cmd_data_d  = cmd_data_q;
    retry_d     = retry_q;
    tmr_load    = 1'b0;
    tmr_us      = '0;
    advance     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d  = ST_RST_ASSERT;
          tmr_load = 1'b1;
          tmr_us   = US_W'(RST_LOW_US);
        end
      end
      ST_RST_ASSERT: begin
        if (tmr_expired_c) begin
          state_d  = ST_RST_WAIT;
          tmr_load = 1'b1;
          tmr_us   = US_W'(RST_WAIT_US);
        end
      end
      ST_RST_WAIT: begin
        if (tmr_expired_c) begin
          state_d    = ST_FETCH;
          tbl_addr_d = '0;
        end
      end
      // Address was presented on entry; ROM data appears in DECODE
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        case (ent_op)
          OP_WRITE: begin
            state_d    = ST_I2C_REQ;
            retry_d    = '0;
            cmd_reg_d  = ent_reg;
            cmd_data_d = ent_val;
          end
          OP_DELAY: begin
            state_d  = ST_DELAY;
            tmr_load = 1'b1;
            tmr_us   = ms_to_us(ent_val);
          end
          OP_END:  state_d = ST_DONE;
          default: begin
            state_d     = ST_ERROR;
            err_index_d = tbl_addr_q;
          end
        endcase
      end
      ST_I2C_REQ: begin
        if (cmd_ready) begin
          state_d = ST_I2C_WAIT;
        end
      end
      ST_I2C_WAIT: begin
        if (rsp_ok) begin
          advance = 1'b1;
        end else if (rsp_fail) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_I2C_REQ;
          end else begin
            state_d     = ST_ERROR;
            err_index_d = tbl_addr_q;
          end
        end
      end
      ST_DELAY: begin
        if (tmr_expired_c) begin
          advance = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A table without END finishes after its last entry
    if (advance) begin
      if (&tbl_addr_q) begin
        state_d = ST_DONE;
      end else begin
        state_d    = ST_FETCH;
        tbl_addr_d = tbl_addr_q + TBL_AW'(1);
      end
    end

    // Moore outputs decoded from the next state so they register in step with it
    cmd_valid_d = (state_d == ST_I2C_REQ);
    busy_d      = !(state_d inside {ST_IDLE, ST_DONE, ST_ERROR});
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERROR);
    cam_rst_t_d = state_d inside {ST_RST_WAIT, ST_FETCH, ST_DECODE, ST_I2C_REQ,
                                  ST_I2C_WAIT, ST_DELAY, ST_DONE};
  end

  always_ff @(posedge clk_50m or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      tbl_addr_q  <= '0;
      err_index_q <= '0;
      cmd_reg_q   <= '0;
      cmd_data_q  <= '0;
      retry_q     <= '0;
      cmd_valid_q <= 1'b0;
      cam_rst_t_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tbl_addr_q  <= tbl_addr_d;
      err_index_q <= err_index_d;
      cmd_reg_q   <= cmd_reg_d;
      cmd_data_q  <= cmd_data_d;
      retry_q     <= retry_d;
      cmd_valid_q <= cmd_valid_d;
      cam_rst_t_q <= cam_rst_t_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // The pin is only ever driven low; release is done through the tristate
  assign cam_rst_o = 1'b0;
  assign cam_rst_t = cam_rst_t_q;
  assign cmd_dev   = DEV_ADDR;
  assign tbl_addr  = tbl_addr_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_reg   = cmd_reg_q;
  assign cmd_data  = cmd_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_index_q;

endmodule

// File: tb/tb_cam_init_seq.sv
// Bench for cam_init_seq: table ROM model, I2C master responder, scoreboard of
// expected write requests compared against the requests the DUT issues.
module tb_cam_init_seq;

  localparam int unsigned CLK_HZ = 5000000;
  localparam int unsigned TD     = 5;      // cycles per microsecond at CLK_HZ
  localparam int unsigned RLOW   = 2;
  localparam int unsigned RWAIT  = 3;
  localparam int unsigned AW     = 6;
  localparam int unsigned MAXR   = 3;
  localparam int unsigned TO     = 50;

  logic          clk_50m = 1'b0;
  logic          reset_in;
  logic          start;
  logic [AW-1:0] tbl_addr;
  logic [31:0]   tbl_data;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [6:0]    cmd_dev;
  logic [15:0]   cmd_reg;
  logic [7:0]    cmd_data;
  logic          rsp_valid;
  logic          rsp_nack;
  logic          cam_rst_o;
  logic          cam_rst_t;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] err_index;

  always #10 clk_50m = ~clk_50m;

  cam_init_seq #(
    .CLK_FREQ_HZ (CLK_HZ),
    .RST_LOW_US  (RLOW),
    .RST_WAIT_US (RWAIT),
    .TBL_AW      (AW),
    .DEV_ADDR    (7'h36),
    .MAX_RETRY   (MAXR)
`ifdef CAM_INIT_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (TO)
`endif
  ) dut (
    .clk_50m   (clk_50m),
    .reset_in  (reset_in),
    .start     (start),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dev   (cmd_dev),
    .cmd_reg   (cmd_reg),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_nack  (rsp_nack),
    .cam_rst_o (cam_rst_o),
    .cam_rst_t (cam_rst_t),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_index (err_index)
  );

  // Table ROM with one cycle of read latency
  logic [31:0] rom [64];
  always @(posedge clk_50m) tbl_data <= rom[tbl_addr];

  int cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  // Scoreboard storage: {dev, reg, data}
  logic [30:0] exp_q[$];
  logic [30:0] obs_q[$];
  int          req_cyc_q[$];
  int          rsp_cyc_q[$];

  bit          rsp_en     = 1'b1;
  logic [15:0] nack_reg   = 16'hFFFF;
  int          nack_limit = 0;
  int          nack_given = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // I2C master model: accepts requests, answers 3 cycles later
  initial begin : responder
    int          pend;
    logic [15:0] cur_reg;
    pend      = 0;
    cur_reg   = '0;
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
    forever begin
      @(negedge clk_50m);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rsp_valid = 1'b1;
          if (cur_reg == nack_reg && nack_given < nack_limit) begin
            rsp_nack = 1'b1;
            nack_given++;
          end
          rsp_cyc_q.push_back(cyc);
        end
      end
      if (cmd_valid && cmd_ready) begin
        obs_q.push_back({cmd_dev, cmd_reg, cmd_data});
        req_cyc_q.push_back(cyc);
        cur_reg = cmd_reg;
        if (rsp_en) pend = 3;
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'hFF00_0000;
    exp_q.delete();
  endtask

  task automatic put(input int idx, input logic [7:0] op, input logic [15:0] r,
                     input logic [7:0] v);
    rom[idx] = {op, r, v};
    if (op == 8'h00) exp_q.push_back({7'h36, r, v});
  endtask

  task automatic pulse_start();
    @(negedge clk_50m);
    start = 1'b1;
    @(negedge clk_50m);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (busy && n < max) begin
      @(negedge clk_50m);
      n++;
    end
  endtask

  task automatic test_reset();
    reset_in  = 1'b1;
    start     = 1'b0;
    cmd_ready = 1'b1;
    clear_rom();
    repeat (3) @(negedge clk_50m);
    n_checks++; if (tbl_addr !== 6'd0) begin n_fail++; $display("FAIL reset_tbl_addr got %0h exp 0", tbl_addr); end
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid got %b exp 0", cmd_valid); end
    n_checks++; if (cmd_reg !== 16'h0 || cmd_data !== 8'h0) begin n_fail++; $display("FAIL reset_cmd_fields got %h/%h exp 0/0", cmd_reg, cmd_data); end
    n_checks++; if (cam_rst_o !== 1'b0 || cam_rst_t !== 1'b0) begin n_fail++; $display("FAIL reset_pin got o=%b t=%b exp 0/0", cam_rst_o, cam_rst_t); end
    n_checks++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_status got %b exp 000", {busy, done, error}); end
    n_checks++; if (err_index !== 6'd0) begin n_fail++; $display("FAIL reset_err_index got %0d exp 0", err_index); end
    n_checks++; if (cmd_dev !== 7'h36) begin n_fail++; $display("FAIL reset_cmd_dev got %h exp 36", cmd_dev); end
    reset_in = 1'b0;
    repeat (4) @(negedge clk_50m);
    n_checks++; if (busy !== 1'b0 || cam_rst_t !== 1'b0) begin n_fail++; $display("FAIL idle_hold got busy=%b t=%b exp 0/0", busy, cam_rst_t); end
  endtask

  task automatic test_power_timing();
    int lo, hi, n, base;
    clear_rom();
    put(0, 8'h00, 16'h0100, 8'h01);
    put(1, 8'h00, 16'h0103, 8'h01);
    put(2, 8'hFF, 16'h0000, 8'h00);
    base = obs_q.size();
    pulse_start();
    n_checks++; if (busy !== 1'b1 || cam_rst_t !== 1'b0) begin n_fail++; $display("FAIL rst_assert_state got busy=%b t=%b exp 1/0", busy, cam_rst_t); end
    lo = 0;
    while (cam_rst_t === 1'b0 && lo < 200) begin lo++; @(negedge clk_50m); end
    n_checks++; if (lo < int'(RLOW*TD) - 2 || lo > int'(RLOW*TD) + 2) begin n_fail++; $display("FAIL rst_low_cycles got %0d exp %0d+/-2", lo, RLOW*TD); end
    hi = 0;
    while (cmd_valid !== 1'b1 && hi < 500) begin hi++; @(negedge clk_50m); end
    n_checks++; if (hi < int'(RWAIT*TD) - 2 || hi > int'(RWAIT*TD) + 2) begin n_fail++; $display("FAIL first_req_latency got %0d exp %0d+/-2", hi, RWAIT*TD); end
    wait_idle(2000, n);
    n_checks++; if ({busy, done, error} !== 3'b010) begin n_fail++; $display("FAIL write_table_status got %b exp 010", {busy, done, error}); end
    n_checks++; if (cam_rst_t !== 1'b1) begin n_fail++; $display("FAIL done_pin_released got %b exp 1", cam_rst_t); end
    n_checks++; if (obs_q.size() - base != exp_q.size()) begin n_fail++; $display("FAIL write_table_count got %0d exp %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [30:0] e, g;
      e = exp_q.pop_front();
      g = (base + i < obs_q.size()) ? obs_q[base + i] : 'x;
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL write_table_req%0d got %h exp %h", i, g, e); end
    end
  endtask

  task automatic test_start_while_busy();
    int n, base;
    exp_q.delete();
    exp_q.push_back({7'h36, 16'h0100, 8'h01});
    exp_q.push_back({7'h36, 16'h0103, 8'h01});
    base = obs_q.size();
    pulse_start();
    n = 0;
    while (cmd_valid !== 1'b1 && n < 500) begin n++; @(negedge clk_50m); end
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL restart_req_timeout got %b exp 1", cmd_valid); end
    pulse_start();
    wait_idle(2000, n);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL busy_start_done got %b exp 1", done); end
    n_checks++; if (obs_q.size() - base != exp_q.size()) begin n_fail++; $display("FAIL busy_start_count got %0d exp %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [30:0] e, g;
      e = exp_q.pop_front();
      g = (base + i < obs_q.size()) ? obs_q[base + i] : 'x;
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL busy_start_req%0d got %h exp %h", i, g, e); end
    end
  endtask

  task automatic test_nack_retry();
    int n, base;
    clear_rom();
    put(0, 8'h00, 16'h3000, 8'h11);
    put(1, 8'h00, 16'h3001, 8'h22);
    put(2, 8'hFF, 16'h0000, 8'h00);
    for (int i = 0; i < int'(MAXR); i++) exp_q.push_back({7'h36, 16'h3001, 8'h22});
    nack_reg   = 16'h3001;
    nack_limit = nack_given + int'(MAXR) + 1;
    base = obs_q.size();
    pulse_start();
    wait_idle(3000, n);
    n_checks++; if ({busy, done, error} !== 3'b001) begin n_fail++; $display("FAIL nack_status got %b exp 001", {busy, done, error}); end
    n_checks++; if (err_index !== 6'd1) begin n_fail++; $display("FAIL nack_err_index got %0d exp 1", err_index); end
    n_checks++; if (cam_rst_t !== 1'b0) begin n_fail++; $display("FAIL nack_pin_driven got %b exp 0", cam_rst_t); end
    n_checks++; if (obs_q.size() - base != exp_q.size()) begin n_fail++; $display("FAIL nack_req_count got %0d exp %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [30:0] e, g;
      e = exp_q.pop_front();
      g = (base + i < obs_q.size()) ? obs_q[base + i] : 'x;
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL nack_req%0d got %h exp %h", i, g, e); end
    end
    nack_reg = 16'hFFFF;
  endtask

  task automatic test_delay();
    int n, base, rbase, delta, d;
    clear_rom();
    put(0, 8'h00, 16'h0100, 8'hAA);
    put(1, 8'h01, 16'h0000, 8'h02);
    put(2, 8'h00, 16'h0200, 8'hBB);
    put(3, 8'hFF, 16'h0000, 8'h00);
    base  = obs_q.size();
    rbase = rsp_cyc_q.size();
    pulse_start();
    wait_idle(20000, n);
    n_checks++; if (done !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL delay_status got done=%b err=%b exp 1/0", done, error); end
    n_checks++; if (obs_q.size() - base != exp_q.size()) begin n_fail++; $display("FAIL delay_req_count got %0d exp %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [30:0] e, g;
      e = exp_q.pop_front();
      g = (base + i < obs_q.size()) ? obs_q[base + i] : 'x;
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL delay_req%0d got %h exp %h", i, g, e); end
    end
    // 2 ms plus a few cycles of fetch/decode overhead around the delay
    d     = 2 * 1000 * int'(TD);
    delta = (obs_q.size() > base + 1 && rsp_cyc_q.size() > rbase) ? req_cyc_q[base + 1] - rsp_cyc_q[rbase] : -1;
    n_checks++; if (delta < d || delta > d + 6) begin n_fail++; $display("FAIL delay_gap got %0d exp %0d..%0d", delta, d, d + 6); end
  endtask

  task automatic test_zero_delay_bad_op();
    int n, base;
    clear_rom();
    put(0, 8'h01, 16'h0000, 8'h00);
    put(1, 8'h00, 16'h000A, 8'h05);
    put(2, 8'h7E, 16'h1234, 8'h56);
    base = obs_q.size();
    pulse_start();
    wait_idle(2000, n);
    n_checks++; if ({busy, done, error} !== 3'b001) begin n_fail++; $display("FAIL bad_op_status got %b exp 001", {busy, done, error}); end
    n_checks++; if (err_index !== 6'd2) begin n_fail++; $display("FAIL bad_op_err_index got %0d exp 2", err_index); end
    n_checks++; if (obs_q.size() - base != 1) begin n_fail++; $display("FAIL bad_op_req_count got %0d exp 1", obs_q.size() - base); end
    if (obs_q.size() > base) begin
      logic [30:0] e;
      e = exp_q.pop_front();
      n_checks++; if (obs_q[base] !== e) begin n_fail++; $display("FAIL bad_op_req got %h exp %h", obs_q[base], e); end
    end
  endtask

  task automatic test_last_entry();
    int n, base;
    clear_rom();
    for (int i = 0; i < 63; i++) put(i, 8'h01, 16'h0000, 8'h00);
    put(63, 8'h00, 16'h3F3F, 8'h3F);
    base = obs_q.size();
    pulse_start();
    wait_idle(3000, n);
    n_checks++; if ({busy, done, error} !== 3'b010) begin n_fail++; $display("FAIL last_entry_status got %b exp 010", {busy, done, error}); end
    n_checks++; if (tbl_addr !== 6'd63) begin n_fail++; $display("FAIL last_entry_addr got %0d exp 63", tbl_addr); end
    n_checks++; if (obs_q.size() - base != 1) begin n_fail++; $display("FAIL last_entry_count got %0d exp 1", obs_q.size() - base); end
    if (obs_q.size() > base) begin
      logic [30:0] e;
      e = exp_q.pop_front();
      n_checks++; if (obs_q[base] !== e) begin n_fail++; $display("FAIL last_entry_req got %h exp %h", obs_q[base], e); end
    end
  endtask

  task automatic test_mid_reset();
    int n, base;
    clear_rom();
    put(0, 8'h00, 16'h5000, 8'h01);
    put(1, 8'h00, 16'h5001, 8'h02);
    put(2, 8'hFF, 16'h0000, 8'h00);
    rsp_en = 1'b0;
    pulse_start();
    n = 0;
    while (cmd_valid !== 1'b1 && n < 500) begin n++; @(negedge clk_50m); end
    repeat (4) @(negedge clk_50m);
    n_checks++; if (busy !== 1'b1 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL in_wait got busy=%b valid=%b exp 1/0", busy, cmd_valid); end
    #5;
    reset_in = 1'b1;
    #1;
    n_checks++; if ({cmd_valid, busy, cam_rst_t} !== 3'b000) begin n_fail++; $display("FAIL mid_reset got valid/busy/t=%b exp 000", {cmd_valid, busy, cam_rst_t}); end
    @(negedge clk_50m);
    reset_in = 1'b0;
    rsp_en   = 1'b1;
    base = obs_q.size();
    pulse_start();
    wait_idle(2000, n);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rerun_done got %b exp 1", done); end
    n_checks++; if (obs_q.size() - base != exp_q.size()) begin n_fail++; $display("FAIL rerun_count got %0d exp %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [30:0] e, g;
      e = exp_q.pop_front();
      g = (base + i < obs_q.size()) ? obs_q[base + i] : 'x;
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL rerun_req%0d got %h exp %h", i, g, e); end
    end
  endtask

`ifdef CAM_INIT_TIMEOUT_EN
  task automatic test_timeout();
    int n, base;
    clear_rom();
    put(0, 8'h00, 16'h7000, 8'h33);
    put(1, 8'hFF, 16'h0000, 8'h00);
    rsp_en = 1'b0;
    base = obs_q.size();
    pulse_start();
    wait_idle(3000, n);
    n_checks++; if ({busy, done, error} !== 3'b001) begin n_fail++; $display("FAIL timeout_status got %b exp 001", {busy, done, error}); end
    n_checks++; if (obs_q.size() - base != int'(MAXR) + 1) begin n_fail++; $display("FAIL timeout_req_count got %0d exp %0d", obs_q.size() - base, MAXR + 1); end
    for (int i = 1; i <= int'(MAXR) && base + i < req_cyc_q.size(); i++) begin
      int gap;
      gap = req_cyc_q[base + i] - req_cyc_q[base + i - 1];
      n_checks++; if (gap < int'(TO) || gap > int'(TO) + 5) begin n_fail++; $display("FAIL timeout_gap%0d got %0d exp %0d..%0d", i, gap, TO, TO + 5); end
    end
    rsp_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_power_timing();
    test_start_while_busy();
    test_nack_retry();
    test_delay();
    test_zero_delay_bad_op();
    test_last_entry();
    test_mid_reset();
`ifdef CAM_INIT_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
